// File: rtl/control_types.sv
// Shared CPU control encodings; mem_op_t selects access size and load sign extension.
package control_types;

  typedef enum logic [2:0] {
    MEM_B  = 3'd0,
    MEM_H  = 3'd1,
    MEM_W  = 3'd2,
    MEM_BU = 3'd4,
    MEM_HU = 3'd5
  } mem_op_t;

endpackage

// File: rtl/mem_arb_pkg.sv
// Arbiter FSM encoding and the starvation-counter sizing shared by dmem_arbiter.
package mem_arb_pkg;

  typedef enum logic {
    S_CPU,
    S_FORCE
  } arb_state_t;

  localparam int unsigned MAX_WAIT_MIN = 1;
  localparam int unsigned MAX_WAIT_MAX = 15;
  localparam int unsigned CNT_W        = $clog2(MAX_WAIT_MAX + 1);

endpackage

// File: rtl/dmem_arbiter_if.sv
// Bundles the CPU, debug and data_memory sides of the arbiter; slave is the arbiter's view.
interface dmem_arbiter_if
  import control_types::*;
#(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
);

  logic              cpu_req;
  logic              cpu_wr_en;
  mem_op_t           cpu_op;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic [DATA_W-1:0] cpu_rdata;
  logic              cpu_stall;

  logic              dbg_valid;
  logic              dbg_ready;
  logic              dbg_wr_en;
  mem_op_t           dbg_op;
  logic [ADDR_W-1:0] dbg_addr;
  logic [DATA_W-1:0] dbg_wdata;
  logic              dbg_rsp_valid;
  logic [DATA_W-1:0] dbg_rdata;

  logic              mem_wr_en;
  mem_op_t           mem_op;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  cpu_req, cpu_wr_en, cpu_op, cpu_addr, cpu_wdata,
    output cpu_rdata, cpu_stall,
    input  dbg_valid, dbg_wr_en, dbg_op, dbg_addr, dbg_wdata,
    output dbg_ready, dbg_rsp_valid, dbg_rdata,
    output mem_wr_en, mem_op, mem_addr, mem_wdata,
    input  mem_rdata
  );

  modport master (
    output cpu_req, cpu_wr_en, cpu_op, cpu_addr, cpu_wdata,
    input  cpu_rdata, cpu_stall,
    output dbg_valid, dbg_wr_en, dbg_op, dbg_addr, dbg_wdata,
    input  dbg_ready, dbg_rsp_valid, dbg_rdata,
    input  mem_wr_en, mem_op, mem_addr, mem_wdata,
    output mem_rdata
  );

endinterface

// File: rtl/dmem_arbiter_sat_counter.sv
// Saturating up-counter; hit flags the increment that reaches MAX.
module sat_counter #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned MAX   = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  input  logic             clr,
  output logic [WIDTH-1:0] count,
  output logic             hit
);

  localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MAX);

  logic [WIDTH-1:0] count_inc;

  always_comb begin
    count_inc = (count == MAX_V) ? count : count + WIDTH'(1);
  end

  assign hit = inc && !clr && (count_inc == MAX_V);

  always_ff @(posedge clk) begin
    if (reset || clr) begin
      count <= '0;
    end else if (inc) begin
      count <= count_inc;
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares data_memory between the CPU (priority) and a debug requester that steals idle
// cycles or, after MAX_WAIT contended cycles, takes a forced slot while the CPU stalls.
module dmem_arbiter
  import control_types::*;
  import mem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W   = 32,
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned MAX_WAIT = 4
) (
  input  logic           clk,
  input  logic           reset,
  dmem_arbiter_if.slave  bus
);

  arb_state_t        state;
  logic [CNT_W-1:0]  wait_cnt;
  logic              wait_hit;
  logic              cnt_inc;
  logic              force_slot;
  logic              idle_steal;
  logic              dbg_accept;
  logic [ADDR_W-1:0] addr_sel;
  logic [DATA_W-1:0] wdata_sel;

  // Reset overrides the held state so a pending forced slot is never granted.
  assign force_slot = !reset && (state == S_FORCE) && bus.dbg_valid;
  assign idle_steal = !reset && (state == S_CPU) && !bus.cpu_req && bus.dbg_valid;
  assign cnt_inc    = !reset && (state == S_CPU) && bus.cpu_req && bus.dbg_valid;
  assign dbg_accept = bus.dbg_valid && bus.dbg_ready;

  sat_counter #(
    .WIDTH (CNT_W),
    .MAX   (MAX_WAIT)
  ) u_wait (
    .clk   (clk),
    .reset (reset),
    .inc   (cnt_inc),
    .clr   (!cnt_inc),
    .count (wait_cnt),
    .hit   (wait_hit)
  );

  always_comb begin
    addr_sel      = bus.cpu_addr;
    wdata_sel     = bus.cpu_wdata;
    bus.mem_wr_en = bus.cpu_req && bus.cpu_wr_en;
    bus.mem_op    = bus.cpu_op;
    bus.cpu_rdata = bus.mem_rdata;
    bus.cpu_stall = 1'b0;
    bus.dbg_ready = 1'b0;
    if (force_slot || idle_steal) begin
      addr_sel      = bus.dbg_addr;
      wdata_sel     = bus.dbg_wdata;
      bus.mem_wr_en = bus.dbg_wr_en;
      bus.mem_op    = bus.dbg_op;
      bus.dbg_ready = 1'b1;
    end
    if (force_slot) begin
      bus.cpu_stall = bus.cpu_req;
      bus.cpu_rdata = '0;
    end
  end

  assign bus.mem_addr  = addr_sel;
  assign bus.mem_wdata = wdata_sel;

  always_ff @(posedge clk) begin
    if (reset) begin
      state             <= S_CPU;
      bus.dbg_rsp_valid <= 1'b0;
      bus.dbg_rdata     <= '0;
    end else begin
      bus.dbg_rsp_valid <= dbg_accept;
      if (dbg_accept && !bus.dbg_wr_en) begin
        bus.dbg_rdata <= bus.mem_rdata;
      end
      unique case (state)
        S_CPU:   if (wait_hit) state <= S_FORCE;
        S_FORCE: state <= S_CPU;
        default: state <= S_CPU;
      endcase
    end
  end

endmodule
